// File: rtl/l1i_fetch_arbiter.sv
// Round-robin arbiter sharing the single L1I read port between fetch threads t0 and t1.
// Each accepted fetch runs IDLE -> ISSUE -> (WAIT) -> RESP, with a timeout on the cache response.
module l1i_fetch_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              t0_enable,
    input  logic              t1_enable,
    input  logic              t0_req,
    input  logic [ADDR_W-1:0] t0_addr,
    output logic              t0_gnt,
    output logic              t0_rvalid,
    output logic [DATA_W-1:0] t0_rdata,
    output logic              t0_err,
    input  logic              t1_req,
    input  logic [ADDR_W-1:0] t1_addr,
    output logic              t1_gnt,
    output logic              t1_rvalid,
    output logic [DATA_W-1:0] t1_rdata,
    output logic              t1_err,
    output logic              l1i_rd_en,
    output logic [ADDR_W-1:0] l1i_addr,
    input  logic [DATA_W-1:0] l1i_rdata,
    input  logic              l1i_rd_valid,
    output logic              busy,
    output logic              owner
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] l1i_addr_q, l1i_addr_d;
    logic              t0_gnt_q, t0_gnt_d, t1_gnt_q, t1_gnt_d;
    logic              t0_rvalid_q, t0_rvalid_d, t1_rvalid_q, t1_rvalid_d;
    logic [DATA_W-1:0] t0_rdata_q, t0_rdata_d, t1_rdata_q, t1_rdata_d;
    logic              t0_err_q, t0_err_d, t1_err_q, t1_err_d;
    logic              elig0, elig1, pick, accept, resp;

    assign elig0 = t0_req & t0_enable;
    assign elig1 = t1_req & t1_enable;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        timer_d      = timer_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        pick         = 1'b0;

        case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    pick    = (elig0 && elig1) ? ~last_owner_q : elig1;
                    owner_d = pick;
                    addr_d  = pick ? t1_addr : t0_addr;
                    timer_d = '0;
                    // Misaligned fetches never reach the cache; they answer with an error directly.
                    if (addr_d[1:0] != 2'b00) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                timer_d = '0;
                if (l1i_rd_valid) begin
                    rdata_d = l1i_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (l1i_rd_valid) begin
                    rdata_d = l1i_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timer_q == TIMER_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered: derive them from the state being entered.
        accept      = (state_q == IDLE) && (state_d != IDLE);
        resp        = (state_d == RESP);
        busy_d      = (state_d != IDLE);
        rd_en_d     = (state_d == ISSUE);
        l1i_addr_d  = rd_en_d ? addr_d : '0;
        t0_gnt_d    = accept && !owner_d;
        t1_gnt_d    = accept && owner_d;
        t0_rvalid_d = resp && !owner_d;
        t1_rvalid_d = resp && owner_d;
        t0_rdata_d  = t0_rvalid_d ? rdata_d : '0;
        t1_rdata_d  = t1_rvalid_d ? rdata_d : '0;
        t0_err_d    = t0_rvalid_d && err_d;
        t1_err_d    = t1_rvalid_d && err_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            timer_q      <= '0;
            addr_q       <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            l1i_addr_q   <= '0;
            t0_gnt_q     <= 1'b0;
            t1_gnt_q     <= 1'b0;
            t0_rvalid_q  <= 1'b0;
            t1_rvalid_q  <= 1'b0;
            t0_rdata_q   <= '0;
            t1_rdata_q   <= '0;
            t0_err_q     <= 1'b0;
            t1_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            timer_q      <= timer_d;
            addr_q       <= addr_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            rd_en_q      <= rd_en_d;
            l1i_addr_q   <= l1i_addr_d;
            t0_gnt_q     <= t0_gnt_d;
            t1_gnt_q     <= t1_gnt_d;
            t0_rvalid_q  <= t0_rvalid_d;
            t1_rvalid_q  <= t1_rvalid_d;
            t0_rdata_q   <= t0_rdata_d;
            t1_rdata_q   <= t1_rdata_d;
            t0_err_q     <= t0_err_d;
            t1_err_q     <= t1_err_d;
        end
    end

    assign t0_gnt    = t0_gnt_q;
    assign t1_gnt    = t1_gnt_q;
    assign t0_rvalid = t0_rvalid_q;
    assign t1_rvalid = t1_rvalid_q;
    assign t0_rdata  = t0_rdata_q;
    assign t1_rdata  = t1_rdata_q;
    assign t0_err    = t0_err_q;
    assign t1_err    = t1_err_q;
    assign l1i_rd_en = rd_en_q;
    assign l1i_addr  = l1i_addr_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: doc/l1i_fetch_arbiter.md
Name: l1i_fetch_arbiter

Overview:
Shares the single L1I read port between hardware threads t0 and t1. Each thread's fetch unit raises a request with a 64-bit instruction address. The arbiter picks one thread by round-robin, drives l1i_rd_en/l1i_addr, waits for the cache response (with timeout), and returns the 32-bit instruction word to the owning thread. It sits in the core between the two thread fetch stages and the l1i instance.

Parameters:
ADDR_W, 64, instruction address width
DATA_W, 32, instruction word width
TIMEOUT, 255, max cycles in WAIT before an error response (must be >= 1)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
t0_enable  in  1  thread 0 allowed to issue fetches
t1_enable  in  1  thread 1 allowed to issue fetches
t0_req  in  1  thread 0 fetch request, held until t0_gnt
t0_addr  in  ADDR_W  thread 0 fetch address
t0_gnt  out  1  one-cycle pulse: t0 request accepted
t0_rvalid  out  1  one-cycle pulse: t0 response valid
t0_rdata  out  DATA_W  t0 instruction word
t0_err  out  1  t0 response is an error (misaligned or timeout), qualified by t0_rvalid
t1_req, t1_addr, t1_gnt, t1_rvalid, t1_rdata, t1_err  same as t0, for thread 1
l1i_rd_en  out  1  L1I read strobe, one cycle per access
l1i_addr  out  ADDR_W  L1I read address
l1i_rdata  in  DATA_W  L1I read data
l1i_rd_valid  in  1  L1I read data valid
busy  out  1  arbiter not in IDLE
owner  out  1  thread currently owning the port (0/1); valid while busy

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; last_owner=1 (so t0 wins the first tie); timer=0; latched addr and rdata = 0.
- All outputs registered; eligible_tX = tX_req & tX_enable.
- IDLE:
  - no eligible request -> stay.
  - one eligible -> pick it.
  - both eligible -> pick ~last_owner.
  - Latch addr and owner. If addr[1:0] != 0, go RESP with err=1 (no cache access); else go ISSUE.
- ISSUE, 1 cycle:
  - l1i_rd_en=1, l1i_addr=latched addr, tX_gnt=1 for the owner; timer cleared.
  - Misaligned path: gnt is pulsed in the RESP cycle instead.
  - l1i_rd_valid sampled this cycle: if 1, latch l1i_rdata and go RESP; else go WAIT.
- WAIT:
  - l1i_rd_valid=1 -> latch rdata, err=0, go RESP.
  - else timer++; when timer==TIMEOUT -> go RESP with err=1, rdata=0.
- RESP, 1 cycle:
  - owner's tX_rvalid=1 with tX_rdata/tX_err.
  - last_owner <= owner; go IDLE.
  - Non-owner outputs stay 0.
- Min turnaround: 3 cycles (IDLE, ISSUE, RESP) when the cache answers in the ISSUE cycle. Requests are not sampled outside IDLE.
- l1i_rd_valid outside ISSUE/WAIT is ignored, including late data after a timeout.
- Enable deassert mid-transaction: the transaction completes and the response is delivered. Enable gates acceptance only.
- A requester holding req after gnt is re-accepted as a new fetch at the next IDLE (requester's responsibility).
- Reset mid-transaction: immediate return to reset state; no rvalid is issued.
- busy=1 in ISSUE/WAIT/RESP. owner reflects the latched owner.

Test Plan:
- Single t0 fetch, addr=0x0000_0000_0000_0004, cache returns 0x1111_2222 two cycles after rd_en -> l1i_rd_en pulse with addr 0x…04; t0_gnt pulse; t0_rvalid=1, t0_rdata=0x11112222, t0_err=0; no t1 outputs.
- t0 and t1 both requesting continuously, both enabled, zero-latency cache -> grants alternate t0,t1,t0,t1; each transaction is 3 cycles.
- t1_req=1 with t1_enable=0 -> no grant or l1i_rd_en for 20 cycles. Then assert t1_enable -> granted on the next IDLE.
- t0_addr=0x…06 (misaligned) -> no l1i_rd_en; t0_rvalid=1, t0_err=1, t0_rdata=0.
- TIMEOUT=4, cache never responds -> after 4 WAIT cycles t0_rvalid=1, t0_err=1. An l1i_rd_valid pulse 2 cycles later is ignored; busy=0.
- Assert rst=0 during WAIT -> all outputs 0 asynchronously, busy=0. After release, a t1-only request is granted, and a tie is resolved to t0.
